// File: rtl/cby_cfg_shadow.sv
// Y-direction connection block: straight-through vertical tracks, NUM_IPIN tap muxes
// driven from a load-strobed shadow of a scan chain, and one embedded SoC IO.
module cby_ipin_mux #(
  parameter int MUX_SIZE = 10,
  parameter int SEL_BITS = 4
) (
  input  logic [MUX_SIZE-1:0] in_i,
  input  logic [SEL_BITS-1:0] sel_i,
  output logic                out_o
);
  localparam logic [SEL_BITS:0] LIMIT = (SEL_BITS+1)'(MUX_SIZE);

  // Unpopulated select codes park the pin low instead of aliasing a tap.
  assign out_o = ({1'b0, sel_i} < LIMIT) ? in_i[sel_i] : 1'b0;
endmodule

module cby_cfg_shadow #(
  parameter int CHAN_WIDTH = 20,
  parameter int NUM_IPIN   = 2,
  parameter int MUX_SIZE   = 10,
  parameter int TAP_STRIDE = 2
) (
  input  logic                  prog_clk,
  input  logic                  prog_rst_n,
  input  logic [CHAN_WIDTH-1:0] chany_bottom_in,
  input  logic [CHAN_WIDTH-1:0] chany_top_in,
  output logic [CHAN_WIDTH-1:0] chany_bottom_out,
  output logic [CHAN_WIDTH-1:0] chany_top_out,
  output logic [NUM_IPIN-1:0]   left_grid_pin,
  input  logic                  ccff_head,
  input  logic                  ccff_en,
  input  logic                  ccff_load,
  output logic                  ccff_tail,
  output logic                  cfg_done,
  output logic                  cfg_err,
  input  logic                  gfpga_pad_EMBEDDED_IO_SOC_IN,
  output logic                  gfpga_pad_EMBEDDED_IO_SOC_OUT,
  output logic                  gfpga_pad_EMBEDDED_IO_SOC_DIR,
  input  logic                  right_width_0_height_0__pin_0_,
  output logic                  right_width_0_height_0__pin_1_upper,
  output logic                  right_width_0_height_0__pin_1_lower
);
  localparam int SEL_BITS = $clog2(MUX_SIZE);
  localparam int CFG_BITS = NUM_IPIN*SEL_BITS + 1;
  localparam int CNT_W    = $clog2(CFG_BITS + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_BITS);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CFG_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CFG_BITS-1:0] shift_q, shift_d;
  logic [CFG_BITS-1:0] shadow_q, shadow_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  always_comb begin
    shift_d  = shift_q;
    shadow_d = shadow_q;
    cnt_d    = cnt_q;
    done_d   = done_q;
    err_d    = err_q;
    if (ccff_en) begin
      shift_d = {shift_q[CFG_BITS-2:0], ccff_head};
      if (cnt_q != CNT_SAT) cnt_d = cnt_q + CNT_ONE;
    end
    // Load captures the pre-shift chain; a coincident shift starts the next count.
    if (ccff_load) begin
      shadow_d = shift_q;
      done_d   = (cnt_q == CNT_FULL);
      err_d    = err_q | (cnt_q != CNT_FULL);
      cnt_d    = ccff_en ? CNT_ONE : '0;
    end
  end

  always_ff @(posedge prog_clk) begin
    if (!prog_rst_n) begin
      shift_q  <= '0;
      shadow_q <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      shift_q  <= shift_d;
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign ccff_tail = shift_q[CFG_BITS-1];
  assign cfg_done  = done_q;
  assign cfg_err   = err_q;

  assign chany_top_out    = chany_bottom_in;
  assign chany_bottom_out = chany_top_in;

  logic [NUM_IPIN-1:0][MUX_SIZE-1:0] mux_in;

  for (genvar k = 0; k < NUM_IPIN; k++) begin : g_ipin
    // Tap pairs walk the channel from track 2k; even inputs from below, odd from above.
    for (genvar j = 0; j < MUX_SIZE; j++) begin : g_tap
      localparam int T = (2*k + (j/2)*TAP_STRIDE) % CHAN_WIDTH;
      if (j % 2 == 0) begin : g_bot
        assign mux_in[k][j] = chany_bottom_in[T];
      end else begin : g_top
        assign mux_in[k][j] = chany_top_in[T];
      end
    end

    cby_ipin_mux #(.MUX_SIZE(MUX_SIZE), .SEL_BITS(SEL_BITS)) u_mux (
      .in_i  (mux_in[k]),
      .sel_i (shadow_q[k*SEL_BITS +: SEL_BITS]),
      .out_o (left_grid_pin[k])
    );
  end

  logic io_dir;
  assign io_dir = shadow_q[CFG_BITS-1];

  assign gfpga_pad_EMBEDDED_IO_SOC_OUT       = right_width_0_height_0__pin_0_;
  assign gfpga_pad_EMBEDDED_IO_SOC_DIR       = io_dir;
  assign right_width_0_height_0__pin_1_upper = io_dir ? 1'b0 : gfpga_pad_EMBEDDED_IO_SOC_IN;
  assign right_width_0_height_0__pin_1_lower = right_width_0_height_0__pin_1_upper;
endmodule

// File: tb/tb_cby_cfg_shadow.sv
// Bench for cby_cfg_shadow: directed vector table, corner sequences, and random
// traffic checked every cycle against an integer-arithmetic reference model.
module tb_cby_cfg_shadow;
  localparam int CW  = 20;
  localparam int NI  = 2;
  localparam int CFG = 9;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [CW-1:0] bot_in = '0, top_in = '0;
  logic [CW-1:0] bot_out, top_out;
  logic [NI-1:0] pins;
  logic          head = 1'b0, en = 1'b0, load = 1'b0;
  logic          tail, done, err;
  logic          soc_in = 1'b0, soc_out, soc_dir;
  logic          pin0 = 1'b0, upper, lower;

  cby_cfg_shadow dut (
    .prog_clk                            (clk),
    .prog_rst_n                          (rst_n),
    .chany_bottom_in                     (bot_in),
    .chany_top_in                        (top_in),
    .chany_bottom_out                    (bot_out),
    .chany_top_out                       (top_out),
    .left_grid_pin                       (pins),
    .ccff_head                           (head),
    .ccff_en                             (en),
    .ccff_load                           (load),
    .ccff_tail                           (tail),
    .cfg_done                            (done),
    .cfg_err                             (err),
    .gfpga_pad_EMBEDDED_IO_SOC_IN        (soc_in),
    .gfpga_pad_EMBEDDED_IO_SOC_OUT       (soc_out),
    .gfpga_pad_EMBEDDED_IO_SOC_DIR       (soc_dir),
    .right_width_0_height_0__pin_0_      (pin0),
    .right_width_0_height_0__pin_1_upper (upper),
    .right_width_0_height_0__pin_1_lower (lower)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model state: chain, shadow and counter as plain integers.
  int m_sr = 0, m_sh = 0, m_cnt = 0;
  bit m_done = 0, m_err = 0;

  // Current track/IO stimulus used by step().
  logic [CW-1:0] cur_b = '0, cur_t = '0;
  logic          cur_p0 = 1'b0, cur_si = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic m_pin(input int k, input int sh, input logic [CW-1:0] b,
                                 input logic [CW-1:0] t);
    int sel, tr;
    sel = (sh >> (k*4)) & 15;
    if (sel >= 10) return 1'b0;
    tr = (2*k + (sel/2)*2) % CW;
    return (sel % 2 == 1) ? t[tr] : b[tr];
  endfunction

  task automatic m_edge(input logic r, input logic e, input logic h, input logic l);
    int old_sr, old_cnt;
    if (!r) begin
      m_sr = 0; m_sh = 0; m_cnt = 0; m_done = 0; m_err = 0;
      return;
    end
    old_sr = m_sr;
    old_cnt = m_cnt;
    if (e) begin
      m_sr = ((m_sr << 1) | int'(h)) & 'h1FF;
      m_cnt = (m_cnt + 1 > CFG + 1) ? CFG + 1 : m_cnt + 1;
    end
    if (l) begin
      m_sh = old_sr;
      m_done = (old_cnt == CFG);
      m_err = m_err | (old_cnt != CFG);
      m_cnt = e ? 1 : 0;
    end
  endtask

  task automatic step(input logic r, input logic e, input logic h, input logic l);
    logic dir;
    @(negedge clk);
    rst_n = r; en = e; head = h; load = l;
    bot_in = cur_b; top_in = cur_t; pin0 = cur_p0; soc_in = cur_si;
    @(posedge clk);
    m_edge(r, e, h, l);
    #1;
    dir = m_sh[8];
    chk("top_out", 32'(top_out), 32'(cur_b));
    chk("bottom_out", 32'(bot_out), 32'(cur_t));
    chk("ipin0_model", 32'(pins[0]), 32'(m_pin(0, m_sh, cur_b, cur_t)));
    chk("ipin1_model", 32'(pins[1]), 32'(m_pin(1, m_sh, cur_b, cur_t)));
    chk("tail_model", 32'(tail), 32'(m_sr[8]));
    chk("done_model", 32'(done), 32'(m_done));
    chk("err_model", 32'(err), 32'(m_err));
    chk("dir_model", 32'(soc_dir), 32'(dir));
    chk("soc_out", 32'(soc_out), 32'(cur_p0));
    chk("upper_model", 32'(upper), 32'(dir ? 1'b0 : cur_si));
    chk("lower_model", 32'(lower), 32'(dir ? 1'b0 : cur_si));
  endtask

  task automatic shift_word(input logic [8:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) step(1'b1, 1'b1, w[i], 1'b0);
  endtask

  typedef struct {
    logic          rst_n, en, head, load;
    logic [CW-1:0] b, t;
    logic          p0, si;
    logic          e_done, e_err, e_tail;
    logic [1:0]    e_pins;
    logic          e_dir, e_upper;
  } vec_t;

  vec_t tbl[18];

  initial begin
    logic [8:0] w;
    int n;

    // Reset, program 1_0011_0101, load, then shift 5 without loading (no glitch), short load.
    tbl[0] = '{1'b0,1'b0,1'b0,1'b0, 20'h5A5A5,20'hA5A5A, 1'b1,1'b1, 1'b0,1'b0,1'b0, 2'b11, 1'b0,1'b1};
    w = 9'b1_0011_0101;
    for (int i = 0; i < 9; i++)
      tbl[1+i] = '{1'b1,1'b1,w[8-i],1'b0, 20'h5A5A5,20'hA5A5A, 1'(i%2),1'b0,
                   1'b0,1'b0,(i == 8) ? 1'b1 : 1'b0, 2'b11, 1'b0,1'b0};
    tbl[10] = '{1'b1,1'b0,1'b0,1'b1, 20'hFFFFF,20'h00010, 1'b1,1'b1, 1'b1,1'b0,1'b1, 2'b11, 1'b1,1'b0};
    tbl[11] = '{1'b1,1'b0,1'b0,1'b0, 20'hFFFFF,20'h00000, 1'b0,1'b1, 1'b1,1'b0,1'b1, 2'b00, 1'b1,1'b0};
    tbl[12] = '{1'b1,1'b1,1'b0,1'b0, 20'hFFFFF,20'h00000, 1'b1,1'b1, 1'b1,1'b0,1'b0, 2'b00, 1'b1,1'b0};
    tbl[13] = '{1'b1,1'b1,1'b0,1'b0, 20'hFFFFF,20'h00010, 1'b0,1'b1, 1'b1,1'b0,1'b0, 2'b11, 1'b1,1'b0};
    tbl[14] = '{1'b1,1'b1,1'b0,1'b0, 20'hFFFFF,20'h00000, 1'b1,1'b1, 1'b1,1'b0,1'b1, 2'b00, 1'b1,1'b0};
    tbl[15] = '{1'b1,1'b1,1'b0,1'b0, 20'hFFFFF,20'h00010, 1'b0,1'b1, 1'b1,1'b0,1'b1, 2'b11, 1'b1,1'b0};
    tbl[16] = '{1'b1,1'b1,1'b0,1'b0, 20'hFFFFF,20'h00000, 1'b1,1'b1, 1'b1,1'b0,1'b0, 2'b00, 1'b1,1'b0};
    tbl[17] = '{1'b1,1'b0,1'b0,1'b1, 20'hFFFFF,20'h00000, 1'b0,1'b1, 1'b0,1'b1,1'b0, 2'b01, 1'b0,1'b1};

    for (int i = 0; i < 18; i++) begin
      cur_b = tbl[i].b; cur_t = tbl[i].t; cur_p0 = tbl[i].p0; cur_si = tbl[i].si;
      step(tbl[i].rst_n, tbl[i].en, tbl[i].head, tbl[i].load);
      chk($sformatf("tbl%0d_done", i), 32'(done), 32'(tbl[i].e_done));
      chk($sformatf("tbl%0d_err", i), 32'(err), 32'(tbl[i].e_err));
      chk($sformatf("tbl%0d_tail", i), 32'(tail), 32'(tbl[i].e_tail));
      chk($sformatf("tbl%0d_pins", i), 32'(pins), 32'(tbl[i].e_pins));
      chk($sformatf("tbl%0d_dir", i), 32'(soc_dir), 32'(tbl[i].e_dir));
      chk($sformatf("tbl%0d_upper", i), 32'(upper), 32'(tbl[i].e_upper));
    end

    // Correct-length load after an error: done rises, err stays; sel0 = 12 is out of range.
    cur_b = 20'hFFFFF; cur_t = 20'hFFFFF;
    shift_word(9'h00C, 9);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    chk("seqA_done", 32'(done), 32'd1);
    chk("seqA_err_sticky", 32'(err), 32'd1);
    for (int i = 0; i < 4; i++) begin
      cur_b = 20'($urandom); cur_t = 20'($urandom);
      if (i == 0) begin cur_b = 20'hFFFFF; cur_t = 20'hFFFFF; end
      step(1'b1, 1'b0, 1'b0, 1'b0);
      chk("seqA_oor_pin0", 32'(pins[0]), 32'd0);
      chk("seqA_pin1_bot2", 32'(pins[1]), 32'(cur_b[2]));
    end

    // Tail replays the first word in order, one bit per subsequent shift.
    w = 9'h1B6;
    shift_word(w, 9);
    chk("seqB_tail0", 32'(tail), 32'(w[8]));
    for (int i = 1; i < 9; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0);
      chk($sformatf("seqB_tail%0d", i), 32'(tail), 32'(w[8-i]));
    end

    // Reset mid-programming discards the partial chain and the counter.
    shift_word(9'h1FF, 4);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    chk("seqC_rst_err", 32'(err), 32'd0);
    shift_word(9'h127, 9);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    chk("seqC_done", 32'(done), 32'd1);
    chk("seqC_err", 32'(err), 32'd0);
    cur_b = 20'h00010; cur_t = 20'h00040;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("seqC_pins_hi", 32'(pins), 32'd3);
    chk("seqC_dir", 32'(soc_dir), 32'd1);
    cur_b = 20'hFFFEF; cur_t = 20'hFFFBF;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("seqC_pins_lo", 32'(pins), 32'd0);

    // Random programming sessions: right or wrong lengths, overlapping shift/load, resets.
    for (int s = 0; s < 80; s++) begin
      n = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 12) : CFG;
      for (int i = 0; i < n; i++) begin
        cur_b = 20'($urandom); cur_t = 20'($urandom);
        cur_p0 = 1'($urandom); cur_si = 1'($urandom);
        step(($urandom_range(0, 60) != 0), 1'($urandom_range(0, 5) != 0), 1'($urandom), 1'b0);
      end
      cur_b = 20'($urandom); cur_t = 20'($urandom);
      step(1'b1, 1'($urandom_range(0, 3) == 0), 1'($urandom), 1'b1);
      for (int i = 0; i < 3; i++) begin
        cur_b = 20'($urandom); cur_t = 20'($urandom);
        cur_p0 = 1'($urandom); cur_si = 1'($urandom);
        step(1'b1, 1'b0, 1'b0, 1'b0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
